// File: rtl/fwd_scoreboard.sv
// Decode-stage forwarding selects, hazard interlock and
// long-latency pending-write scoreboard.
module fwd_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int WEN_W = 4,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ds_valid,
  input  logic [AW*NSRC-1:0]    ds_rs,
  input  logic [NSRC-1:0]       ds_src_used,
  input  logic [AW-1:0]         ds_rd,
  input  logic                  ds_reg_write,
  input  logic                  es_valid,
  input  logic                  es_reg_write,
  input  logic                  es_is_load,
  input  logic [AW-1:0]         es_rd,
  input  logic                  es_lat_issue,
  input  logic                  ms_valid,
  input  logic                  ms_reg_write,
  input  logic [AW-1:0]         ms_rd,
  input  logic                  ws_valid,
  input  logic                  ws_reg_write,
  input  logic [AW-1:0]         ws_rd,
  input  logic [WEN_W-1:0]      ws_rf_wen,
  input  logic                  lat_done,
  input  logic [AW-1:0]         lat_rd,
  output logic [2*NSRC-1:0]     fwd_sel,
  output logic [WEN_W*NSRC-1:0] fwd_wen,
  output logic                  ds_stall,
  output logic [NREG-1:0]       pend_vec,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  sb_err
);

  logic [NREG-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [NSRC-1:0] lu_haz;
  logic [NSRC-1:0] pd_haz;
  logic            waw_haz;

  logic set_en;
  logic issue_err;
  logic done_err;

  for (genvar g = 0; g < NSRC; g++) begin : g_port
    logic [AW-1:0]    rs;
    logic             live;
    logic             ms_hit;
    logic             ws_hit;
    logic             lat_hit;
    logic [1:0]       sel;
    logic [WEN_W-1:0] wen;

    assign rs      = ds_rs[g*AW +: AW];
    assign live    = ds_valid & ds_src_used[g]
                   & (rs != '0);
    assign ms_hit  = ms_valid & ms_reg_write
                   & (ms_rd == rs);
    assign ws_hit  = ws_valid & ws_reg_write
                   & (ws_rd == rs);
    assign lat_hit = lat_done & (lat_rd == rs);

    assign lu_haz[g] = live & es_valid
                     & es_reg_write & es_is_load
                     & (es_rd == rs);
    assign pd_haz[g] = live & pend_q[rs]
                     & ~lat_hit;

    // Youngest in-flight producer wins the operand mux
    always_comb begin
      sel = 2'd0;
      wen = '1;
      if (live) begin
        if (ms_hit) begin
          sel = 2'd1;
        end else if (ws_hit) begin
          sel = 2'd2;
          wen = ws_rf_wen;
        end else if (lat_hit) begin
          sel = 2'd3;
        end
      end
    end

    assign fwd_sel[2*g +: 2]         = sel;
    assign fwd_wen[WEN_W*g +: WEN_W] = wen;
  end

  assign waw_haz = ds_valid & ds_reg_write
                 & (ds_rd != '0) & pend_q[ds_rd]
                 & ~(lat_done & (lat_rd == ds_rd));

  assign ds_stall = (|lu_haz) | (|pd_haz) | waw_haz;

  assign set_en    = es_valid & es_lat_issue
                   & (es_rd != '0);
  assign issue_err = set_en & pend_q[es_rd]
                   & ~(lat_done & (lat_rd == es_rd));
  assign done_err  = lat_done
                   & ((lat_rd == '0) | ~pend_q[lat_rd]);

  // Next scoreboard state; a new issue beats a same-cycle clear
  always_comb begin
    pend_d = pend_q;
    if (lat_done) pend_d[lat_rd] = 1'b0;
    if (set_en)   pend_d[es_rd]  = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Saturating stall counter and sticky protocol error
  always_comb begin
    cnt_d = cnt_q;
    if (ds_stall && (cnt_q != '1))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    err_d = err_q | issue_err | done_err;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign pend_vec  = pend_q;
  assign stall_cnt = cnt_q;
  assign sb_err    = err_q;

endmodule
